// File: rtl/expr_pkg.sv
// Shared types and constants for the expression sequencer: token kinds,
// controller states and the ASCII operator characters conv understands.
package expr_pkg;

  typedef enum logic [1:0] {
    TK_NUM  = 2'd0,
    TK_SIGN = 2'd1,
    TK_END  = 2'd2,
    TK_RSVD = 2'd3
  } tok_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACK,
    ST_DRAIN,
    ST_FLUSH,
    ST_SETTLE,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] CH_ADD = 8'h2B;
  localparam logic [7:0] CH_SUB = 8'h2D;
  localparam logic [7:0] CH_MUL = 8'h2A;
  localparam logic [7:0] CH_DIV = 8'h2F;

  function automatic logic is_op(input logic [7:0] ch);
    return ch inside {CH_ADD, CH_SUB, CH_MUL, CH_DIV};
  endfunction

endpackage

// File: rtl/expr_tok_fifo.sv
// Small synchronous token FIFO holding {kind, data}; refuses pushes while full
// even if a pop happens in the same cycle, and empties on a synchronous clear.
module expr_tok_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/expr_sequencer.sv
// Token-level controller in front of the conv/man pair: buffers tokens, issues
// one strobe at a time under BUSY backpressure, flushes and captures the result.
module expr_sequencer
  import expr_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255,
  parameter int SETTLE  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        tok_valid,
  output logic        tok_ready,
  input  logic [1:0]  tok_kind,
  input  logic [7:0]  tok_data,
  output logic [7:0]  conv_sign,
  output logic        conv_sign_stb,
  output logic [7:0]  conv_number,
  output logic        conv_number_stb,
  input  logic        conv_busy,
  input  logic        eval_busy,
  input  logic [31:0] eval_result,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        error,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  state_t      state;
  logic [TW-1:0] timer;
  logic [SW-1:0] settle_cnt;
  logic [9:0]  head;
  tok_kind_t   head_kind;
  logic [7:0]  head_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pipe_idle;
  logic        issue_ok;
  logic        pop;

  expr_tok_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (tok_valid),
    .pop   (pop),
    .din   ({tok_kind, tok_data}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tok_ready = !fifo_full;
  assign head_kind = tok_kind_t'(head[9:8]);
  assign head_data = head[7:0];
  assign pipe_idle = !conv_busy && !eval_busy;
  assign issue_ok  = (state == ST_ISSUE) && pipe_idle && !fifo_empty;
  assign pop       = issue_ok && !clr;
  assign busy      = !(state inside {ST_IDLE, ST_DONE, ST_ERR});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      timer           <= '0;
      settle_cnt      <= '0;
      conv_sign       <= '0;
      conv_sign_stb   <= 1'b0;
      conv_number     <= '0;
      conv_number_stb <= 1'b0;
      result          <= '0;
      result_valid    <= 1'b0;
      error           <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (clr) begin
        state           <= ST_IDLE;
        timer           <= '0;
        settle_cnt      <= '0;
        conv_sign_stb   <= 1'b0;
        conv_number_stb <= 1'b0;
        error           <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: if (!fifo_empty) state <= ST_ISSUE;
          ST_ISSUE: begin
            if (issue_ok) begin
              timer <= '0;
              unique case (head_kind)
                TK_NUM: begin
                  conv_number     <= head_data;
                  conv_number_stb <= 1'b1;
                  state           <= ST_ACK;
                end
                TK_SIGN: begin
                  if (is_op(head_data)) begin
                    conv_sign     <= head_data;
                    conv_sign_stb <= 1'b1;
                    state         <= ST_ACK;
                  end else begin
                    error <= 1'b1;
                    state <= ST_ERR;
                  end
                end
                // Both strobes together is conv's flush request.
                TK_END: begin
                  conv_sign_stb   <= 1'b1;
                  conv_number_stb <= 1'b1;
                  state           <= ST_FLUSH;
                end
                default: begin
                  error <= 1'b1;
                  state <= ST_ERR;
                end
              endcase
            end
          end
          ST_ACK, ST_FLUSH: begin
            if (conv_busy) begin
              conv_sign_stb   <= 1'b0;
              conv_number_stb <= 1'b0;
              settle_cnt      <= '0;
              state           <= (state == ST_ACK) ? ST_DRAIN : ST_SETTLE;
            end else if (timer == TIMER_LAST) begin
              conv_sign_stb   <= 1'b0;
              conv_number_stb <= 1'b0;
              error           <= 1'b1;
              state           <= ST_ERR;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_DRAIN: if (pipe_idle) state <= fifo_empty ? ST_IDLE : ST_ISSUE;
          // The evaluator output is only trusted after SETTLE quiet cycles in a row.
          ST_SETTLE: begin
            if (!pipe_idle) begin
              settle_cnt <= '0;
            end else if (settle_cnt == SETTLE_LAST) begin
              result       <= eval_result;
              result_valid <= 1'b1;
              state        <= ST_DONE;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          ST_DONE: if (!fifo_empty) state <= ST_ISSUE;
          ST_ERR: state <= ST_ERR;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_expr_sequencer.sv
// Directed bench for expr_sequencer with small conv/man environment models and
// a token-level reference model checking strobe order and captured results.
module tb_expr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        tok_valid = 1'b0;
  logic        tok_ready;
  logic [1:0]  tok_kind = 2'd0;
  logic [7:0]  tok_data = 8'd0;
  logic [7:0]  conv_sign;
  logic        conv_sign_stb;
  logic [7:0]  conv_number;
  logic        conv_number_stb;
  logic        conv_busy = 1'b0;
  logic        eval_busy = 1'b0;
  logic [31:0] eval_result = 32'd0;
  logic [31:0] result;
  logic        result_valid;
  logic        error;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  expr_sequencer #(
    .DEPTH   (8),
    .TIMEOUT (255),
    .SETTLE  (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clr             (clr),
    .tok_valid       (tok_valid),
    .tok_ready       (tok_ready),
    .tok_kind        (tok_kind),
    .tok_data        (tok_data),
    .conv_sign       (conv_sign),
    .conv_sign_stb   (conv_sign_stb),
    .conv_number     (conv_number),
    .conv_number_stb (conv_number_stb),
    .conv_busy       (conv_busy),
    .eval_busy       (eval_busy),
    .eval_result     (eval_result),
    .result          (result),
    .result_valid    (result_valid),
    .error           (error),
    .busy            (busy)
  );

  localparam logic [1:0] K_NUM  = 2'd0;
  localparam logic [1:0] K_SIGN = 2'd1;
  localparam logic [1:0] K_END  = 2'd2;
  localparam logic [1:0] K_RSVD = 2'd3;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  // Arithmetic with the usual precedence: * and / bind tighter than + and -.
  function automatic int evalExpr(input int nums[16], input int nn, input logic [7:0] ops[16], input int no);
    int v[16];
    logic [7:0] o[16];
    int nv;
    int nop;
    int res;
    nv = 1;
    nop = 0;
    v[0] = (nn > 0) ? nums[0] : 0;
    for (int i = 0; i < no; i++) begin
      if (ops[i] == "*") v[nv-1] = v[nv-1] * nums[i+1];
      else if (ops[i] == "/") v[nv-1] = (nums[i+1] == 0) ? 0 : v[nv-1] / nums[i+1];
      else begin
        o[nop] = ops[i];
        nop++;
        v[nv] = nums[i+1];
        nv++;
      end
    end
    res = v[0];
    for (int j = 0; j < nop; j++) res = (o[j] == "+") ? res + v[j+1] : res - v[j+1];
    return res;
  endfunction

  // Reference model: the stream of strobes and results the pushed tokens must produce.
  logic [9:0]  exp_ev[$];
  int          exp_res[$];
  int          m_nums[16];
  logic [7:0]  m_ops[16];
  int          m_nn = 0;
  int          m_no = 0;

  task automatic modelReset();
    exp_ev.delete();
    exp_res.delete();
    m_nn = 0;
    m_no = 0;
  endtask

  task automatic modelAccept(input logic [1:0] kind, input logic [7:0] data);
    if (kind == K_NUM) begin
      exp_ev.push_back({K_NUM, data});
      m_nums[m_nn] = int'(data);
      m_nn++;
    end else if (kind == K_SIGN) begin
      exp_ev.push_back({K_SIGN, data});
      m_ops[m_no] = data;
      m_no++;
    end else begin
      exp_ev.push_back({K_END, 8'd0});
      exp_res.push_back(evalExpr(m_nums, m_nn, m_ops, m_no));
      m_nn = 0;
      m_no = 0;
    end
  endtask

  // Environment: conv acks a strobe for 3 cycles; man goes busy on flush then presents its answer.
  int          env_mode = 0;
  int          conv_left = 0;
  int          eval_left = 0;
  int          env_nums[16];
  logic [7:0]  env_ops[16];
  int          env_nn = 0;
  int          env_no = 0;
  int          pending_res = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      conv_busy = 1'b0;
      eval_busy = 1'b0;
      conv_left = 0;
      eval_left = 0;
      env_nn = 0;
      env_no = 0;
    end else begin
      if (eval_busy) begin
        if (eval_left == 0) begin
          eval_busy = 1'b0;
          eval_result = pending_res;
        end else eval_left--;
      end
      if (env_mode == 2) conv_busy = 1'b1;
      else if (env_mode == 1) conv_busy = 1'b0;
      else if (conv_busy) begin
        if (conv_left == 0) conv_busy = 1'b0;
        else conv_left--;
      end else if (conv_sign_stb || conv_number_stb) begin
        conv_busy = 1'b1;
        conv_left = 2;
        if (conv_sign_stb && conv_number_stb) begin
          pending_res = evalExpr(env_nums, env_nn, env_ops, env_no);
          env_nn = 0;
          env_no = 0;
          eval_busy = 1'b1;
          eval_left = 3;
          eval_result = 32'hDEAD_BEEF;
        end else if (conv_number_stb) begin
          env_nums[env_nn] = int'(conv_number);
          env_nn++;
        end else begin
          env_ops[env_no] = conv_sign;
          env_no++;
        end
      end
    end
  end

  // Compare process: every new strobe and every capture pulse against the model.
  logic prev_stb = 1'b0;
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    logic [9:0] got;
    if (!rst_n) begin
      prev_stb = 1'b0;
      prev_rv = 1'b0;
    end else begin
      if ((conv_sign_stb || conv_number_stb) && !prev_stb) begin
        if (conv_sign_stb && conv_number_stb) got = {K_END, 8'd0};
        else if (conv_sign_stb) got = {K_SIGN, conv_sign};
        else got = {K_NUM, conv_number};
        if (exp_ev.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected strobe: got kind %0d data %0d, expected none", got[9:8], got[7:0]);
        end else begin
          checkOutput("strobe token {kind,data}", 32'(got), 32'(exp_ev.pop_front()));
        end
      end
      prev_stb = conv_sign_stb || conv_number_stb;
      if (result_valid) begin
        checkOutput("result_valid single-cycle", 32'(prev_rv), 32'd0);
        if (exp_res.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected capture: got result %0d, expected no pulse", result);
        end else begin
          checkOutput("captured result vs model", result, exp_res.pop_front());
        end
      end
      prev_rv = result_valid;
    end
  end

  task automatic applyStimulus(input logic [1:0] kind, input logic [7:0] data, input bit expect_issue);
    int w;
    w = 0;
    while (!tok_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!tok_ready) begin
      checkOutput("tok_ready wait timeout", 32'(tok_ready), 32'd1);
      return;
    end
    tok_valid = 1'b1;
    tok_kind = kind;
    tok_data = data;
    if (expect_issue) modelAccept(kind, data);
    @(negedge clk);
    tok_valid = 1'b0;
  endtask

  task automatic waitCapture(input string name, input int expected);
    int w;
    w = 0;
    while (!result_valid && w < 2000) begin
      @(negedge clk);
      w++;
    end
    checkOutput({name, " pulse seen"}, 32'(result_valid), 32'd1);
    checkOutput(name, result, expected);
    @(negedge clk);
  endtask

  task automatic pulseClear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    modelReset();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int w;
    repeat (3) @(negedge clk);
    checkOutput("reset conv_sign_stb", 32'(conv_sign_stb), 32'd0);
    checkOutput("reset conv_number_stb", 32'(conv_number_stb), 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset result_valid", 32'(result_valid), 32'd0);
    checkOutput("reset error", 32'(error), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset tok_ready", 32'(tok_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 3 + 4
    applyStimulus(K_NUM, 8'd3, 1);
    applyStimulus(K_SIGN, "+", 1);
    applyStimulus(K_NUM, 8'd4, 1);
    applyStimulus(K_END, 8'd0, 1);
    waitCapture("3+4 result", 7);
    repeat (3) @(negedge clk);
    checkOutput("result held after capture", result, 32'd7);
    checkOutput("busy low in DONE", 32'(busy), 32'd0);
    checkOutput("no error after 3+4", 32'(error), 32'd0);

    // Back-to-back expressions
    applyStimulus(K_NUM, 8'd2, 1);
    applyStimulus(K_SIGN, "*", 1);
    applyStimulus(K_NUM, 8'd5, 1);
    applyStimulus(K_END, 8'd0, 1);
    applyStimulus(K_NUM, 8'd8, 1);
    applyStimulus(K_SIGN, "-", 1);
    applyStimulus(K_NUM, 8'd1, 1);
    applyStimulus(K_END, 8'd0, 1);
    waitCapture("2*5 result", 10);
    waitCapture("8-1 result", 7);

    // Fill the FIFO while conv is held busy
    env_mode = 2;
    repeat (2) @(negedge clk);
    applyStimulus(K_NUM, 8'd1, 1);
    applyStimulus(K_SIGN, "+", 1);
    applyStimulus(K_NUM, 8'd2, 1);
    applyStimulus(K_SIGN, "+", 1);
    applyStimulus(K_NUM, 8'd3, 1);
    applyStimulus(K_SIGN, "+", 1);
    applyStimulus(K_NUM, 8'd4, 1);
    checkOutput("tok_ready before 8th", 32'(tok_ready), 32'd1);
    applyStimulus(K_END, 8'd0, 1);
    checkOutput("tok_ready after 8th", 32'(tok_ready), 32'd0);
    tok_valid = 1'b1;
    tok_kind = K_NUM;
    tok_data = 8'd99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("9th token refused", 32'(tok_ready), 32'd0);
    end
    tok_valid = 1'b0;
    env_mode = 0;
    applyStimulus(K_NUM, 8'd6, 1);
    applyStimulus(K_END, 8'd0, 1);
    waitCapture("1+2+3+4 result", 10);
    waitCapture("lone 6 result", 6);

    // Illegal sign
    applyStimulus(K_SIGN, "%", 0);
    repeat (10) @(negedge clk);
    checkOutput("error after percent", 32'(error), 32'd1);
    checkOutput("busy low in ERR", 32'(busy), 32'd0);
    applyStimulus(K_NUM, 8'd5, 0);
    repeat (10) @(negedge clk);
    checkOutput("error sticky", 32'(error), 32'd1);
    checkOutput("no strobe in ERR", 32'(conv_number_stb), 32'd0);
    pulseClear();
    checkOutput("error cleared by clr", 32'(error), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("fifo emptied by clr", 32'(busy), 32'd0);

    // Reserved kind
    applyStimulus(K_RSVD, 8'd0, 0);
    repeat (10) @(negedge clk);
    checkOutput("error after reserved kind", 32'(error), 32'd1);
    pulseClear();
    checkOutput("error cleared after reserved", 32'(error), 32'd0);

    // Strobe never acknowledged
    env_mode = 1;
    applyStimulus(K_NUM, 8'd42, 1);
    w = 0;
    while (!conv_number_stb && w < 50) begin
      @(negedge clk);
      w++;
    end
    checkOutput("timeout strobe issued", 32'(conv_number_stb), 32'd1);
    n = 0;
    while (conv_number_stb && n < 400) begin
      n++;
      @(negedge clk);
    end
    checkOutput("strobe cycles before timeout", 32'(n), 32'd255);
    checkOutput("error after timeout", 32'(error), 32'd1);
    checkOutput("strobe dropped on timeout", 32'(conv_number_stb), 32'd0);
    pulseClear();
    env_mode = 0;
    @(negedge clk);
    checkOutput("error cleared after timeout", 32'(error), 32'd0);
    checkOutput("idle after timeout clear", 32'(busy), 32'd0);

    // Asynchronous reset during ACK
    env_mode = 1;
    applyStimulus(K_NUM, 8'd9, 1);
    applyStimulus(K_SIGN, "+", 1);
    w = 0;
    while (!conv_number_stb && w < 50) begin
      @(negedge clk);
      w++;
    end
    checkOutput("strobe before reset", 32'(conv_number_stb), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset number_stb", 32'(conv_number_stb), 32'd0);
    checkOutput("async reset sign_stb", 32'(conv_sign_stb), 32'd0);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset result", result, 32'd0);
    checkOutput("async reset tok_ready", 32'(tok_ready), 32'd1);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    env_mode = 0;
    repeat (3) @(negedge clk);
    checkOutput("fifo empty after reset", 32'(busy), 32'd0);
    applyStimulus(K_NUM, 8'd6, 1);
    applyStimulus(K_SIGN, "/", 1);
    applyStimulus(K_NUM, 8'd3, 1);
    applyStimulus(K_SIGN, "-", 1);
    applyStimulus(K_NUM, 8'd1, 1);
    applyStimulus(K_END, 8'd0, 1);
    waitCapture("6/3-1 after reset", 1);
    repeat (5) @(negedge clk);
    checkOutput("model strobes all consumed", 32'(exp_ev.size()), 32'd0);
    checkOutput("model results all consumed", 32'(exp_res.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
